out_port_scheduler: RTL and testbench

//  Per-output-port scheduler of the switch. Shares one output port among N_SRC input-side

---
 rtl/out_port_scheduler_pkg.sv | 22 ++
 rtl/out_port_scheduler_if.sv | 29 ++
 rtl/out_port_scheduler_rr_arbiter.sv | 25 ++
 rtl/out_port_scheduler.sv | 143 ++++++++++++++
 tb/tb_out_port_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/out_port_scheduler_pkg.sv
// Shared types and constants for the output-port scheduler.
// Also holds the state encoding and a small one-hot helper.
package out_port_scheduler_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam int unsigned NPorts = 4;

  function automatic int unsigned onehot_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/out_port_scheduler_if.sv
// Source-queue and output-port signals of one scheduler instance.
// The slave side is the scheduler; the master side drives the queues and the sink.
interface out_port_scheduler_if
  import out_port_scheduler_pkg::*;
#(
  parameter int unsigned N_SRC = NPorts
) ();

  logic [N_SRC-1:0]   src_valid;
  logic [N_SRC*8-1:0] src_data;
  logic [N_SRC-1:0]   src_last;
  logic [N_SRC-1:0]   src_pop;
  byte_t              port_out;
  logic               port_ready;
  logic               port_read;
  logic [N_SRC-1:0]   grant;
  logic               stall_err;

  modport master (
    output src_valid, src_data, src_last, port_read,
    input  src_pop, port_out, port_ready, grant, stall_err
  );

  modport slave (
    input  src_valid, src_data, src_last, port_read,
    output src_pop, port_out, port_ready, grant, stall_err
  );

endinterface

// File: rtl/out_port_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr_i,
// wrapping around, so ptr_i itself has the lowest priority.
module out_port_scheduler_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic [PtrW:0] pos;

  // Scan from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    gnt_o = '0;
    pos   = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      pos = {1'b0, ptr_i} + (PtrW + 1)'(k);
      if (pos >= (PtrW + 1)'(N)) pos = pos - (PtrW + 1)'(N);
      if (req_i[pos[PtrW-1:0]]) gnt_o = N'(1) << pos;
    end
  end

endmodule

// File: rtl/out_port_scheduler.sv
// Shares one switch output port among N_SRC packet queues: whole packets are granted
// round-robin, then streamed byte by byte under the port_ready/port_read handshake.
module out_port_scheduler
  import out_port_scheduler_pkg::*;
#(
  parameter int unsigned N_SRC     = NPorts,
  parameter int unsigned IFG       = 1,
  parameter int unsigned STALL_MAX = 255
) (
  input logic                 clk,
  input logic                 rst_n,
  out_port_scheduler_if.slave bus_io
);

  localparam int unsigned PtrW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned GapW   = (IFG > 1) ? $clog2(IFG) : 1;
  localparam int unsigned StallW = $clog2(STALL_MAX + 1);

  logic [1:0]        state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  byte_t             port_out_q, port_out_d;
  logic              port_ready_q, port_ready_d;
  logic              last_loaded_q, last_loaded_d;
  logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
  logic              stall_err_q, stall_err_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;

  logic [N_SRC-1:0]  arb_gnt;
  logic              sel_valid, sel_last;
  byte_t             sel_data;
  logic              load, xfer_done, stall;

  out_port_scheduler_rr_arbiter #(
    .N (N_SRC)
  ) u_arb (
    .req_i (bus_io.src_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) begin
        sel_valid = bus_io.src_valid[i];
        sel_last  = bus_io.src_last[i];
        sel_data  = bus_io.src_data[8*i +: 8];
      end
    end
  end

  assign xfer_done = port_ready_q & bus_io.port_read;
  // A new byte may enter the output register only when it is empty or draining this cycle.
  assign load  = (state_q == StXfer) & sel_valid & ~last_loaded_q &
                 (~port_ready_q | bus_io.port_read);
  assign stall = (state_q == StXfer) & ~sel_valid & ~last_loaded_q & ~port_ready_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    port_out_d    = port_out_q;
    port_ready_d  = port_ready_q;
    last_loaded_d = last_loaded_q;
    stall_cnt_d   = stall_cnt_q;
    stall_err_d   = 1'b0;
    gap_cnt_d     = gap_cnt_q;

    case (state_q)
      StIdle: begin
        stall_cnt_d = '0;
        if (|bus_io.src_valid) begin
          grant_d  = arb_gnt;
          rr_ptr_d = PtrW'(onehot_idx(32'(arb_gnt)));
          state_d  = StXfer;
        end
      end
      StXfer: begin
        if (load) begin
          port_out_d    = sel_data;
          port_ready_d  = 1'b1;
          last_loaded_d = sel_last;
          stall_cnt_d   = '0;
        end else if (xfer_done) begin
          port_ready_d = 1'b0;
          if (last_loaded_q) begin
            grant_d       = '0;
            last_loaded_d = 1'b0;
            gap_cnt_d     = '0;
            state_d       = (IFG > 0) ? StGap : StIdle;
          end
        end
        // Saturating: the error fires once, then the scheduler just keeps waiting.
        if (stall && (stall_cnt_q != StallW'(STALL_MAX))) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
          stall_err_d = (stall_cnt_q == StallW'(STALL_MAX - 1));
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(IFG - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rr_ptr_q      <= PtrW'(N_SRC - 1);
      grant_q       <= '0;
      port_out_q    <= '0;
      port_ready_q  <= 1'b0;
      last_loaded_q <= 1'b0;
      stall_cnt_q   <= '0;
      stall_err_q   <= 1'b0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      port_out_q    <= port_out_d;
      port_ready_q  <= port_ready_d;
      last_loaded_q <= last_loaded_d;
      stall_cnt_q   <= stall_cnt_d;
      stall_err_q   <= stall_err_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign bus_io.src_pop    = load ? grant_q : '0;
  assign bus_io.port_out   = port_out_q;
  assign bus_io.port_ready = port_ready_q;
  assign bus_io.grant      = grant_q;
  assign bus_io.stall_err  = stall_err_q;

endmodule

// File: tb/tb_out_port_scheduler.sv
// Bench for out_port_scheduler: directed scenarios plus random traffic, checked against
// a packet-level model of queues, round-robin order and the byte stream on the port.
module tb_out_port_scheduler;
  import out_port_scheduler_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned IFG_A = 1;
  localparam int unsigned SMAX  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  out_port_scheduler_if #(.N_SRC(N)) ia ();
  out_port_scheduler_if #(.N_SRC(N)) ib ();

  out_port_scheduler #(.N_SRC(N), .IFG(IFG_A), .STALL_MAX(SMAX)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ia)
  );

  out_port_scheduler #(.N_SRC(N), .IFG(0), .STALL_MAX(SMAX)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ib)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0]   sq [N][$];  // {last, byte} per source queue of dut_a
  logic [N-1:0] en_a;
  logic         rd_a;
  logic [N-1:0] va_a;
  logic [7:0]   qb [$];     // 1-byte packets for src2 of dut_b
  logic [7:0]   rx_b [$];
  int           rx_cyc [$];
  int           win_log [$];
  int           cyc;

  // Sampled outputs of dut_a for the directed checks
  logic [N-1:0] s_grant, s_pop;
  logic [7:0]   s_out;
  logic         s_ready, s_err;

  // Reference model state
  int           owner, last_win, quiet;
  logic [7:0]   exp_q [$];
  logic [N-1:0] prev_valid;
  logic         prev_elig, prev_hold;
  logic [7:0]   prev_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int j;
    for (int k = 1; k <= int'(N); k++) begin
      j = (last + k) % int'(N);
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = (owner >= 0) || (quiet > 0);
    for (int i = 0; i < int'(N); i++) if (sq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic push_byte(input int s, input logic [7:0] b, input logic last);
    sq[s].push_back({last, b});
  endtask

  task automatic reset_model();
    for (int i = 0; i < int'(N); i++) sq[i].delete();
    exp_q.delete();
    win_log.delete();
    qb.delete();
    owner      = -1;
    last_win   = int'(N) - 1;
    quiet      = 0;
    prev_valid = '0;
    prev_elig  = 1'b1;
    prev_hold  = 1'b0;
    prev_out   = '0;
  endtask

  task automatic drive();
    logic [N-1:0]   v, l;
    logic [N*8-1:0] d;
    logic [8:0]     h;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (en_a[i] && sq[i].size() > 0) begin
        h = sq[i][0];
        v[i] = 1'b1;
        l[i] = h[8];
        d[8*i +: 8] = h[7:0];
      end
    end
    va_a = v;
    ia.src_valid = v;
    ia.src_last  = l;
    ia.src_data  = d;
    ia.port_read = rd_a;
    ib.src_valid = (qb.size() > 0) ? 4'b0100 : 4'b0000;
    ib.src_last  = 4'b0100;
    ib.src_data  = (qb.size() > 0) ? {8'h00, qb[0], 16'h0000} : '0;
    ib.port_read = 1'b1;
  endtask

  task automatic step();
    logic [N-1:0] g, exp_g;
    logic [8:0]   h;
    logic         elig_now;
    int           w;
    @(negedge clk);
    drive();
    #1;
    g       = ia.grant;
    s_grant = g;
    s_pop   = ia.src_pop;
    s_out   = ia.port_out;
    s_ready = ia.port_ready;
    s_err   = ia.stall_err;
    elig_now = 1'b0;

    if (quiet > 0) begin
      chk("gap_grant", g, 0);
      chk("gap_ready", ia.port_ready, 0);
      elig_now = (quiet == 1);
      quiet--;
    end else if (owner < 0) begin
      w = rr_pick(prev_valid, last_win);
      exp_g = (prev_elig && w >= 0) ? N'(1) << w : '0;
      chk("arb", g, exp_g);
      if (g != 0) begin
        owner    = (w >= 0) ? w : 0;
        last_win = owner;
        win_log.push_back(owner);
        exp_q.delete();
        for (int k = 0; k < sq[owner].size(); k++) begin
          h = sq[owner][k];
          exp_q.push_back(h[7:0]);
          if (h[8]) break;
        end
      end
      elig_now = (g == 0);
    end else begin
      chk("grant_hold", g, N'(1) << owner);
    end

    if (ia.port_ready && rd_a) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexp", ia.port_ready, 0);
      end else begin
        chk("data", ia.port_out, exp_q.pop_front());
        if (exp_q.size() == 0) begin
          owner = -1;
          quiet = IFG_A + 1;
        end
      end
    end

    if (prev_hold) begin
      chk("hold_ready", ia.port_ready, 1);
      chk("hold_data", ia.port_out, prev_out);
    end

    chk("pop_legal", ia.src_pop & ~(va_a & g), 0);
    chk("pop_onehot", ($countones(ia.src_pop) <= 1), 1);
    for (int i = 0; i < int'(N); i++) begin
      if (ia.src_pop[i] && sq[i].size() > 0) void'(sq[i].pop_front());
    end
    prev_valid = va_a;
    prev_elig  = elig_now;
    prev_hold  = ia.port_ready && !rd_a;
    prev_out   = ia.port_out;

    chk("b_grant", ib.grant & 4'b1011, 0);
    if (ib.port_ready) begin
      rx_b.push_back(ib.port_out);
      rx_cyc.push_back(cyc);
    end
    if (ib.src_pop[2] && qb.size() > 0) void'(qb.pop_front());
    cyc++;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (busy() && n < maxc) begin
      step();
      n++;
    end
    chk("drain_busy", busy(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_grant"}, ia.grant, 0);
    chk({tag, "_ready"}, ia.port_ready, 0);
    chk({tag, "_out"}, ia.port_out, 0);
    chk({tag, "_err"}, ia.stall_err, 0);
    chk({tag, "_pop"}, ia.src_pop, 0);
    chk({tag, "_b_grant"}, ib.grant, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, stopping");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, first, base, len, s;
    en_a = '1;
    rd_a = 1'b1;
    cyc  = 0;
    reset_model();
    drive();

    repeat (3) @(negedge clk);
    check_zero_outputs("rst");
    rst_n = 1'b1;

    // Single 3-byte packet from src1
    push_byte(1, 8'hA5, 0); push_byte(1, 8'h3C, 0); push_byte(1, 8'h02, 1);
    step(); chk("t2_g0", s_grant, 4'b0000);
    step(); chk("t2_g1", s_grant, 4'b0010); chk("t2_pop1", s_pop, 4'b0010);
    step(); chk("t2_rdy2", s_ready, 1); chk("t2_b0", s_out, 8'hA5);
    step(); chk("t2_b1", s_out, 8'h3C);
    step(); chk("t2_b2", s_out, 8'h02);
    step(); chk("t2_g5", s_grant, 4'b0000); chk("t2_rdy5", s_ready, 0);
    step(); chk("t2_g6", s_grant, 4'b0000);

    // Backpressure mid-packet
    push_byte(0, 8'h11, 0); push_byte(0, 8'h22, 0); push_byte(0, 8'h33, 0);
    push_byte(0, 8'h44, 0); push_byte(0, 8'h55, 1);
    repeat (4) step();
    rd_a = 1'b0;
    repeat (3) begin
      step();
      chk("bp_pop", s_pop, 0);
      chk("bp_ready", s_ready, 1);
      chk("bp_out", s_out, 8'h33);
    end
    rd_a = 1'b1;
    drain(50);

    // Source stall mid-packet
    for (int k = 0; k < 6; k++) push_byte(3, 8'(8'hC0 + k), k == 5);
    repeat (3) step();
    en_a[3] = 1'b0;
    pulses = 0;
    first  = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (s_err) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("stall_pulses", pulses, 1);
    chk("stall_when", (first >= int'(SMAX) && first <= int'(SMAX) + 2), 1);
    chk("stall_grant", s_grant, 4'b1000);
    en_a = '1;
    drain(50);

    // Reset in the middle of a packet, then round-robin from src0
    for (int k = 0; k < 4; k++) push_byte(2, 8'(8'h70 + k), k == 3);
    repeat (3) step();
    chk("mid_grant", s_grant, 4'b0100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("arst");
    reset_model();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        push_byte(i, 8'(16 * i + 2 * r), 0);
        push_byte(i, 8'(16 * i + 2 * r + 1), 1);
      end
    end
    drain(200);
    chk("rr_count", win_log.size(), 8);
    for (int k = 0; k < win_log.size() && k < 8; k++) chk("rr_order", win_log[k], k % 4);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        s   = int'($urandom_range(0, N - 1));
        len = int'($urandom_range(1, 4));
        if (sq[s].size() < 12) begin
          for (int k = 0; k < len; k++) push_byte(s, 8'($urandom), k == len - 1);
        end
      end
      rd_a = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < int'(N); i++) en_a[i] = ($urandom_range(0, 9) != 0);
      step();
    end
    en_a = '1;
    rd_a = 1'b1;
    drain(1000);

    // Back-to-back 1-byte packets with no inter-frame gap
    rx_b.delete();
    rx_cyc.delete();
    base = cyc;
    qb.push_back(8'hDE); qb.push_back(8'hAD); qb.push_back(8'hBE); qb.push_back(8'hEF);
    repeat (14) step();
    chk("b_count", rx_b.size(), 4);
    for (int k = 0; k < rx_b.size() && k < 4; k++) begin
      chk("b_cycle", rx_cyc[k] - base, 2 + 3 * k);
    end
    if (rx_b.size() >= 4) begin
      chk("b_byte0", rx_b[0], 8'hDE);
      chk("b_byte1", rx_b[1], 8'hAD);
      chk("b_byte2", rx_b[2], 8'hBE);
      chk("b_byte3", rx_b[3], 8'hEF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
